// File: rtl/serial_mag_comparator.sv
// Serial word magnitude comparator: folds per-bit L/E/G results (MSB first) into a lt/eq/gt word result.
// Optional macro SERIAL_CMP_ONEHOT_CHECK_EN flags words containing non-one-hot L/E/G encodings on err.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic bit_l,
  input  logic bit_e,
  input  logic bit_g,
  output logic busy,
  output logic lt,
  output logic eq,
  output logic gt,
  output logic done,
  output logic err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, ACCUM} state_t;
  typedef enum logic [1:0] {RES_EQUAL, RES_LESS, RES_GREATER} result_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             decided_reg, decided_next;
  result_t          result_reg, result_next;
  logic             lt_reg, lt_next;
  logic             eq_reg, eq_next;
  logic             gt_reg, gt_next;
  logic             done_reg, done_next;

  // Result after folding in the bit consumed this cycle.
  result_t          bit_result;
  logic             bit_decided;

`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
  logic bad_reg, bad_next;
  logic err_reg, err_next;
  logic bit_onehot;
  logic word_bad;

  assign bit_onehot = ({bit_l, bit_e, bit_g} == 3'b100) ||
                      ({bit_l, bit_e, bit_g} == 3'b010) ||
                      ({bit_l, bit_e, bit_g} == 3'b001);
  assign err = err_reg;
`else
  // Equal bits leave the result untouched, so bit_e carries no information here.
  logic unused_bit_e;
  assign unused_bit_e = bit_e;
  assign err = 1'b0;
`endif

  assign busy = (state_reg == ACCUM);
  assign lt   = lt_reg;
  assign eq   = eq_reg;
  assign gt   = gt_reg;
  assign done = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      decided_reg <= 1'b0;
      result_reg  <= RES_EQUAL;
      lt_reg      <= 1'b0;
      eq_reg      <= 1'b0;
      gt_reg      <= 1'b0;
      done_reg    <= 1'b0;
`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
      bad_reg     <= 1'b0;
      err_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      decided_reg <= decided_next;
      result_reg  <= result_next;
      lt_reg      <= lt_next;
      eq_reg      <= eq_next;
      gt_reg      <= gt_next;
      done_reg    <= done_next;
`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
      bad_reg     <= bad_next;
      err_reg     <= err_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    decided_next = decided_reg;
    result_next  = result_reg;
    lt_next      = lt_reg;
    eq_next      = eq_reg;
    gt_next      = gt_reg;
    done_next    = 1'b0;
    bit_result   = result_reg;
    bit_decided  = decided_reg;
`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
    bad_next     = bad_reg;
    err_next     = err_reg;
    word_bad     = bad_reg | ~bit_onehot;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = ACCUM;
          count_next   = '0;
          decided_next = 1'b0;
          result_next  = RES_EQUAL;
`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
          bad_next     = 1'b0;
`endif
        end
      end

      ACCUM: begin
        if (bit_valid) begin
          // First non-equal bit wins; L takes priority over G on malformed input.
          if (!decided_reg) begin
            if (bit_l) begin
              bit_result  = RES_LESS;
              bit_decided = 1'b1;
            end else if (bit_g) begin
              bit_result  = RES_GREATER;
              bit_decided = 1'b1;
            end
          end
          count_next   = count_reg + CNT_W'(1);
          result_next  = bit_result;
          decided_next = bit_decided;
`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
          bad_next     = word_bad;
`endif
          if (count_reg == LAST_IDX) begin
            state_next = IDLE;
            done_next  = 1'b1;
            lt_next    = (bit_result == RES_LESS);
            eq_next    = (bit_result == RES_EQUAL);
            gt_next    = (bit_result == RES_GREATER);
`ifdef SERIAL_CMP_ONEHOT_CHECK_EN
            err_next   = word_bad;
            if (word_bad) begin
              lt_next = 1'b0;
              eq_next = 1'b0;
              gt_next = 1'b0;
            end
`endif
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
